// File: rtl/sound_mixer.sv
// N-channel audio mixer: per-channel gain with a one-step-per-tick envelope ramp,
// time-multiplexed multiply-accumulate on the 3 MHz strobe, saturated output per 6 kHz tick.
module sound_mixer #(
  parameter int NUM_CH    = 4,
  parameter int IN_W      = 4,
  parameter int GAIN_W    = 4,
  parameter int OUT_W     = 16,
  parameter int MIX_SHIFT = 8,
  localparam int SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clk_3MHz_en,
  input  logic                     clk_6KHz_en,
  input  logic [NUM_CH*IN_W-1:0]   ch_in,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic                     master_mute,
  input  logic                     gain_we,
  input  logic [SEL_W-1:0]         gain_sel,
  input  logic [GAIN_W-1:0]        gain_val,
  output logic [OUT_W-1:0]         audio,
  output logic                     sample_valid,
  output logic                     busy,
  output logic                     clip,
  output logic                     overrun
);

  localparam int PROD_W = IN_W + GAIN_W;
  localparam int ACC_W  = PROD_W + $clog2(NUM_CH) + 1;
  localparam int SCL_W  = ACC_W + MIX_SHIFT;
  localparam int CMP_W  = (SCL_W > OUT_W) ? SCL_W : OUT_W;

  localparam logic [GAIN_W-1:0] G_ONE  = GAIN_W'(1);
  localparam logic [SEL_W-1:0]  K_ONE  = SEL_W'(1);
  localparam logic [SEL_W-1:0]  K_LAST = SEL_W'(NUM_CH - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, SCALE} state_t;

  state_t             state_q, state_d;
  logic [GAIN_W-1:0]  gain [NUM_CH];
  logic [GAIN_W-1:0]  env  [NUM_CH];
  logic [IN_W-1:0]    snap_in_p0  [NUM_CH];
  logic [GAIN_W-1:0]  snap_env_p0 [NUM_CH];
  logic [SEL_W-1:0]   k_q;
  logic [ACC_W-1:0]   acc_p1;
  logic [PROD_W-1:0]  prod_p1;
  logic [OUT_W:0]     sat_p2;
  logic [OUT_W-1:0]   audio_q;

  // Move one LSB toward the target per tick so gain changes never click.
  function automatic logic [GAIN_W-1:0] env_step(input logic [GAIN_W-1:0] cur,
                                                 input logic [GAIN_W-1:0] tgt);
    if (cur < tgt)      return cur + G_ONE;
    else if (cur > tgt) return cur - G_ONE;
    else                return cur;
  endfunction

  // Returns {clip, sample}; the shift is evaluated wide enough that nothing is lost.
  function automatic logic [OUT_W:0] saturate(input logic [ACC_W-1:0] a);
    logic [CMP_W-1:0] s;
    logic [CMP_W-1:0] lim;
    s   = CMP_W'(a) << MIX_SHIFT;
    lim = CMP_W'({OUT_W{1'b1}});
    if (s > lim) return {1'b1, {OUT_W{1'b1}}};
    else         return {1'b0, s[OUT_W-1:0]};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_CH; k++) begin
        gain[k] <= '1;
        env[k]  <= '0;
      end
    end else begin
      if (clk_6KHz_en) begin
        for (int k = 0; k < NUM_CH; k++)
          env[k] <= env_step(env[k], (ch_en[k] && !master_mute) ? gain[k] : '0);
      end
      if (gain_we && (int'(gain_sel) < NUM_CH))
        gain[gain_sel] <= gain_val;
    end
  end

  // Stage p0: capture samples and pre-update envelope at mix start
  always_ff @(posedge clk) begin
    if (state_q == IDLE && clk_6KHz_en) begin
      for (int k = 0; k < NUM_CH; k++) begin
        snap_in_p0[k]  <= ch_in[k*IN_W +: IN_W];
        snap_env_p0[k] <= env[k];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (clk_6KHz_en) state_d = ACCUM;
      ACCUM:   if (clk_3MHz_en && k_q == K_LAST) state_d = SCALE;
      SCALE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage p1: one multiply-accumulate per counted strobe
  assign prod_p1 = PROD_W'(snap_in_p0[k_q]) * PROD_W'(snap_env_p0[k_q]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      acc_p1  <= '0;
      audio_q <= '0;
      overrun <= 1'b0;
    end else begin
      state_q <= state_d;
      if (clk_6KHz_en && state_q != IDLE)
        overrun <= 1'b1;
      case (state_q)
        IDLE: begin
          if (clk_6KHz_en) begin
            acc_p1 <= '0;
            k_q    <= '0;
          end
        end
        ACCUM: begin
          if (clk_3MHz_en) begin
            acc_p1 <= acc_p1 + ACC_W'(prod_p1);
            k_q    <= k_q + K_ONE;
          end
        end
        SCALE:   audio_q <= sat_p2[OUT_W-1:0];
        default: ;
      endcase
    end
  end

  // Stage p2: scale and saturate, presented during the SCALE cycle
  assign sat_p2       = saturate(acc_p1);
  assign sample_valid = (state_q == SCALE);
  assign busy         = (state_q != IDLE);
  assign clip         = sample_valid & sat_p2[OUT_W];
  assign audio        = sample_valid ? sat_p2[OUT_W-1:0] : audio_q;

endmodule

// File: tb/tb_sound_mixer.sv
// Scoreboard bench for sound_mixer: a behavioural model predicts each mixed sample and
// the cycle it appears; a negedge monitor compares everything the DUT presents.
module tb_sound_mixer;
  localparam int N  = 4;
  localparam int IW = 4;
  localparam int GW = 4;
  localparam int OW = 16;
  localparam int MS = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en3 = 1'b0;
  logic          tick = 1'b0;
  logic [N*IW-1:0] ch_in = '0;
  logic [N-1:0]  ch_en = '0;
  logic          master_mute = 1'b0;
  logic          gain_we = 1'b0;
  logic [1:0]    gain_sel = '0;
  logic [GW-1:0] gain_val = '0;
  logic [OW-1:0] audio;
  logic          sample_valid, busy, clip, overrun;

  always #5 clk = ~clk;

  sound_mixer #(.NUM_CH(N), .IN_W(IW), .GAIN_W(GW), .OUT_W(OW), .MIX_SHIFT(MS)) dut (
    .clk(clk), .rst(rst), .clk_3MHz_en(en3), .clk_6KHz_en(tick),
    .ch_in(ch_in), .ch_en(ch_en), .master_mute(master_mute),
    .gain_we(gain_we), .gain_sel(gain_sel), .gain_val(gain_val),
    .audio(audio), .sample_valid(sample_valid), .busy(busy), .clip(clip), .overrun(overrun)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  bit mon_on = 0;

  typedef struct { int audio; bit clip; int edge_no; } exp_t;
  exp_t q[$];

  // Reference model state: phase 0 idle, 1 accumulating, 2 presenting result
  int m_env[N], m_gain[N], m_sin[N], m_senv[N];
  int m_phase = 0, m_steps = 0, m_audio = 0;
  bit m_ovr = 0;

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Applies the effect of the upcoming clock edge number e to the model.
  task automatic model_edge(input int e);
    int ph;
    longint sum, s;
    int tgt;
    if (rst) begin
      for (int k = 0; k < N; k++) begin m_env[k] = 0; m_gain[k] = 15; end
      m_phase = 0; m_ovr = 0; m_audio = 0;
      return;
    end
    ph = m_phase;
    if (ph == 2) m_phase = 0;
    if (tick) begin
      if (ph == 0) begin
        for (int k = 0; k < N; k++) begin
          m_sin[k]  = int'(ch_in[k*IW +: IW]);
          m_senv[k] = m_env[k];
        end
        m_steps = 0;
        m_phase = 1;
      end else m_ovr = 1;
    end
    if (ph == 1 && en3) begin
      m_steps++;
      if (m_steps == N) begin
        sum = 0;
        for (int k = 0; k < N; k++) sum += m_sin[k] * m_senv[k];
        s = sum << MS;
        m_audio = (s > 65535) ? 65535 : int'(s);
        q.push_back('{m_audio, (s > 65535), e});
        m_phase = 2;
      end
    end
    if (tick) begin
      for (int k = 0; k < N; k++) begin
        tgt = (ch_en[k] && !master_mute) ? m_gain[k] : 0;
        if (m_env[k] < tgt) m_env[k]++;
        else if (m_env[k] > tgt) m_env[k]--;
      end
    end
    if (gain_we && int'(gain_sel) < N) m_gain[gain_sel] = int'(gain_val);
  endtask

  task automatic step(input bit tk, input bit e3);
    @(negedge clk);
    #2;
    tick = tk;
    en3  = e3;
    model_edge(cyc + 1);
    @(posedge clk);
    #1;
  endtask

  task automatic mix_tick(input int period, input int en_every);
    step(1'b1, 1'b0);
    for (int i = 1; i < period; i++) step(1'b0, (i % en_every) == 0);
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      chk("audio_hold", audio, m_audio);
      chk("overrun", overrun, m_ovr);
      chk("busy", busy, m_phase != 0);
      if (sample_valid) begin
        if (q.size() == 0) chk("unexpected_valid", 1, 0);
        else begin
          exp_t x;
          x = q.pop_front();
          chk("mix_audio", audio, x.audio);
          chk("mix_clip", clip, x.clip);
          chk("mix_latency", cyc, x.edge_no);
        end
      end else begin
        chk("clip_idle", clip, 0);
        if (q.size() > 0 && q[0].edge_no <= cyc) begin
          chk("missing_valid", 0, 1);
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    repeat (3) step(1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_audio", audio, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_clip", clip, 0);
    chk("rst_overrun", overrun, 0);
    mon_on = 1;

    // All channels full scale: ramp up then saturate
    ch_en = 4'hF; ch_in = 16'hFFFF;
    repeat (18) mix_tick(12, 2);
    chk("t1_steady_sat", audio, 65535);

    // Single channel steady state
    ch_en = 4'h1;
    repeat (18) mix_tick(12, 2);
    chk("t2_steady", audio, 57600);

    // Disable channel 0: gradual ramp down
    ch_en = 4'h0;
    repeat (17) mix_tick(12, 2);
    chk("t3_silent", audio, 0);

    // Gain write coinciding with a tick
    ch_en = 4'hF; ch_in = 16'h3579;
    repeat (16) mix_tick(12, 2);
    gain_we = 1'b1; gain_sel = 2'd1; gain_val = 4'd7;
    step(1'b1, 1'b0);
    gain_we = 1'b0;
    for (int i = 1; i < 12; i++) step(1'b0, (i % 2) == 0);
    repeat (10) mix_tick(12, 2);

    // Tick while busy sets sticky overrun; current mix completes
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    ch_in = 16'h0000;
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    repeat (4) step(1'b0, 1'b0);
    chk("t5_overrun_sticky", overrun, 1);
    ch_in = 16'hFFFF;
    repeat (3) mix_tick(12, 2);

    // Reset in the middle of accumulation
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    rst = 1'b1;
    step(1'b0, 1'b1);
    rst = 1'b0;
    chk("t6_audio", audio, 0);
    chk("t6_busy", busy, 0);
    chk("t6_valid", sample_valid, 0);
    chk("t6_overrun", overrun, 0);
    ch_en = 4'hF;
    mix_tick(12, 2);
    chk("t6_first_mix", audio, 0);

    // Randomized traffic: input churn during mixes, random strobes and gain writes
    for (int t = 0; t < 60; t++) begin
      int per;
      per = $urandom_range(6, 20);
      ch_en = 4'($urandom);
      master_mute = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 2) == 0) begin
        gain_we = 1'b1; gain_sel = 2'($urandom); gain_val = 4'($urandom);
      end
      ch_in = 16'($urandom);
      step(1'b1, 1'($urandom));
      gain_we = 1'b0;
      for (int i = 1; i < per; i++) begin
        ch_in = 16'($urandom);
        ch_en = 4'($urandom);
        step(1'b0, $urandom_range(0, 2) != 0);
      end
    end
    master_mute = 1'b0;
    repeat (30) step(1'b0, 1'b1);
    chk("queue_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
